// File: rtl/rst_pkg.sv
// Shared types and helpers for the register status table: entry layout,
// default sizing and the pending-tag compare used by every lookup.
package rst_pkg;

    localparam int RST_NREGS = 32;
    localparam int RST_TAG_W = 6;

    typedef struct packed {
        logic                 pend;
        logic [RST_TAG_W-1:0] tag;
    } rst_entry_t;

    // An entry is woken by a broadcast only while it is still waiting on that tag.
    function automatic logic tag_match(input rst_entry_t e, input logic valid,
                                       input logic [RST_TAG_W-1:0] tag);
        return e.pend && valid && (e.tag == tag);
    endfunction

endpackage

// File: rtl/rst_src_read.sv
// Resolves one source operand: x0, then lower-slot forwarding, then CDB
// bypass, then the stored entry.
module rst_src_read
    import rst_pkg::*;
#(
    parameter int NREGS  = RST_NREGS,
    parameter int TAG_W  = RST_TAG_W,
    parameter int DISP_W = 2,
    parameter int CDB_N  = 2,
    parameter int SLOT   = 0,
    parameter int AW     = $clog2(NREGS)
) (
    input  logic [AW-1:0]                   i_addr,
    input  rst_entry_t                      i_entry,
    input  logic [DISP_W-1:0]               i_disp_we,
    input  logic [DISP_W-1:0][AW-1:0]       i_disp_rd,
    input  logic [DISP_W-1:0][TAG_W-1:0]    i_disp_tag,
    input  logic [CDB_N-1:0]                i_cdb_valid,
    input  logic [CDB_N-1:0][TAG_W-1:0]     i_cdb_tag,
    output logic                            o_pend,
    output logic [TAG_W-1:0]                o_tag
);

    logic             w_fwd;
    logic [TAG_W-1:0] w_fwd_tag;
    logic             w_bypass;

    always_comb begin
        w_fwd     = 1'b0;
        w_fwd_tag = '0;
        // Later iterations overwrite, so the highest lower slot wins.
        for (int k = 0; k < DISP_W; k++) begin
            if (k < SLOT && i_disp_we[k] && i_disp_rd[k] == i_addr) begin
                w_fwd     = 1'b1;
                w_fwd_tag = i_disp_tag[k];
            end
        end
        w_bypass = 1'b0;
        for (int j = 0; j < CDB_N; j++) begin
            if (tag_match(i_entry, i_cdb_valid[j], i_cdb_tag[j]))
                w_bypass = 1'b1;
        end
        if (i_addr == '0) begin
            o_pend = 1'b0;
            o_tag  = '0;
        end else if (w_fwd) begin
            o_pend = 1'b1;
            o_tag  = w_fwd_tag;
        end else if (w_bypass) begin
            o_pend = 1'b0;
            o_tag  = i_entry.tag;
        end else begin
            o_pend = i_entry.pend;
            o_tag  = i_entry.tag;
        end
    end

endmodule

// File: rtl/reg_status_table.sv
// Register status table: per-register {pend, tag} with multi-slot rename,
// multi-port CDB wake-up, flush and a pending-entry counter.
module reg_status_table
    import rst_pkg::*;
#(
    parameter int NREGS  = RST_NREGS,
    parameter int TAG_W  = RST_TAG_W,
    parameter int DISP_W = 2,
    parameter int CDB_N  = 2,
    parameter int CNT_W  = $clog2(NREGS + 1),
    parameter int AW     = $clog2(NREGS)
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [DISP_W-1:0]               disp_we,
    input  logic [DISP_W-1:0][AW-1:0]       disp_rd,
    input  logic [DISP_W-1:0][TAG_W-1:0]    disp_tag,
    input  logic [DISP_W-1:0][AW-1:0]       rs1_addr,
    input  logic [DISP_W-1:0][AW-1:0]       rs2_addr,
    output logic [DISP_W-1:0][TAG_W-1:0]    rs1_tag,
    output logic [DISP_W-1:0][TAG_W-1:0]    rs2_tag,
    output logic [DISP_W-1:0]               rs1_pend,
    output logic [DISP_W-1:0]               rs2_pend,
    input  logic [CDB_N-1:0]                cdb_valid,
    input  logic [CDB_N-1:0][TAG_W-1:0]     cdb_tag,
    output logic [CDB_N-1:0]                cdb_hit,
    output logic [CDB_N-1:0][AW-1:0]        cdb_rd,
    input  logic                            flush,
    output logic [CNT_W-1:0]                pend_cnt
);

    rst_entry_t       r_tab [NREGS];
    rst_entry_t       w_next [NREGS];
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt;

    // Per-entry next state; statement order gives flush > dispatch > clear.
    always_comb begin
        w_cnt = '0;
        for (int e = 0; e < NREGS; e++) begin
            w_next[e] = r_tab[e];
            for (int j = 0; j < CDB_N; j++) begin
                if (tag_match(r_tab[e], cdb_valid[j], cdb_tag[j]))
                    w_next[e].pend = 1'b0;
            end
            for (int i = 0; i < DISP_W; i++) begin
                if (disp_we[i] && disp_rd[i] == AW'(e)) begin
                    w_next[e].pend = 1'b1;
                    w_next[e].tag  = disp_tag[i];
                end
            end
            if (flush || e == 0)
                w_next[e] = '0;
            w_cnt = w_cnt + CNT_W'(w_next[e].pend);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int e = 0; e < NREGS; e++)
                r_tab[e] <= '0;
            r_cnt <= '0;
        end else begin
            for (int e = 0; e < NREGS; e++)
                r_tab[e] <= w_next[e];
            r_cnt <= w_cnt;
        end
    end

    assign pend_cnt = r_cnt;

    // Tags are unique, so OR-ing matching indices is a one-hot encoder.
    always_comb begin
        for (int j = 0; j < CDB_N; j++) begin
            cdb_hit[j] = 1'b0;
            cdb_rd[j]  = '0;
            for (int e = 0; e < NREGS; e++) begin
                if (tag_match(r_tab[e], cdb_valid[j], cdb_tag[j])) begin
                    cdb_hit[j] = 1'b1;
                    cdb_rd[j]  = cdb_rd[j] | AW'(e);
                end
            end
        end
    end

    for (genvar g = 0; g < DISP_W; g++) begin : g_slot
        rst_src_read #(
            .NREGS(NREGS), .TAG_W(TAG_W), .DISP_W(DISP_W), .CDB_N(CDB_N), .SLOT(g), .AW(AW)
        ) u_rs1 (
            .i_addr(rs1_addr[g]), .i_entry(r_tab[rs1_addr[g]]),
            .i_disp_we(disp_we), .i_disp_rd(disp_rd), .i_disp_tag(disp_tag),
            .i_cdb_valid(cdb_valid), .i_cdb_tag(cdb_tag),
            .o_pend(rs1_pend[g]), .o_tag(rs1_tag[g])
        );
        rst_src_read #(
            .NREGS(NREGS), .TAG_W(TAG_W), .DISP_W(DISP_W), .CDB_N(CDB_N), .SLOT(g), .AW(AW)
        ) u_rs2 (
            .i_addr(rs2_addr[g]), .i_entry(r_tab[rs2_addr[g]]),
            .i_disp_we(disp_we), .i_disp_rd(disp_rd), .i_disp_tag(disp_tag),
            .i_cdb_valid(cdb_valid), .i_cdb_tag(cdb_tag),
            .o_pend(rs2_pend[g]), .o_tag(rs2_tag[g])
        );
    end

endmodule

// File: doc/reg_status_table.md
# reg_status_table

Parametrised register status table for the out-of-order RISC-V core. It tracks, for every architectural register, whether the latest value is pending on an in-flight tag or ready in the register file. Compared with the single-port table it replaces, it adds:
- multiple dispatch (rename) slots with intra-group dependency forwarding;
- multiple CDB broadcast ports with same-cycle read bypass;
- a pipeline flush;
- a pending-entry counter.

It sits between decode/dispatch, the reservation stations and the register file write-back path.

## Interface
Parameters:
- NREGS, 32, architectural register count (power of two); AW = $clog2(NREGS)
- TAG_W, 6, ROB/RS tag width
- DISP_W, 2, dispatch slots per cycle; each slot has one rd write and two source reads
- CDB_N, 2, CDB broadcast ports
- CNT_W, $clog2(NREGS+1), pending counter width

Ports (per-slot/per-port signals are packed arrays indexed [i]):
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- disp_we  in  DISP_W  slot i renames its rd
- disp_rd  in  DISP_W×AW  destination register of slot i
- disp_tag  in  DISP_W×TAG_W  tag allocated to slot i
- rs1_addr, rs2_addr  in  DISP_W×AW  source registers of slot i
- rs1_tag, rs2_tag  out  DISP_W×TAG_W  producing tag of each source
- rs1_pend, rs2_pend  out  DISP_W  1 = source must wait on its tag; 0 = read the register file
- cdb_valid  in  CDB_N  broadcast j valid
- cdb_tag  in  CDB_N×TAG_W  broadcast tag j
- cdb_hit  out  CDB_N  tag j is the current mapping of some register
- cdb_rd  out  CDB_N×AW  register matched by tag j; 0 when cdb_hit is 0
- flush  in  1  mispredict/exception recovery
- pend_cnt  out  CNT_W  number of pending entries

## Operation
- State: NREGS entries, each {pend, tag}. Reset and flush both force all entries to {0, 0}.
- Entry 0 is hard-wired ready. Dispatch to rd 0 is ignored. Reads of x0 return pend=0, tag=0.
- Dispatch: slot i with disp_we[i] and disp_rd[i]≠0 sets entry rd to {1, disp_tag[i]}. If several slots write the same rd, the highest slot index wins.
- CDB clear: entry e is cleared when it is pending and e.tag equals cdb_tag[j] with cdb_valid[j]. Compares run in parallel across all entries and ports, with no priority chain. Tags are unique, so at most one entry matches per port.
- cdb_hit/cdb_rd are combinational from the current state. They assert on a match even when a same-cycle dispatch re-renames that register, because the register file still takes the value.
- Priority per entry within a cycle: flush > dispatch > CDB clear. A dispatch to an entry whose old tag is broadcast leaves the entry pending on the new tag.
- Read resolution for source s of slot i, in descending priority:
  1. If s = 0, return ready.
  2. If a lower slot k<i writes s this cycle, return {1, disp_tag[k]}, taking the highest such k.
  3. If the stored entry is pending and its tag matches a valid CDB tag this cycle, return pend=0 (CDB bypass).
  4. Otherwise return the stored entry.
- A slot's own rd never forwards to its own sources; the reads see the old mapping.
- flush does not gate the read outputs. Dispatch is stalled externally during flush.
- pend_cnt: registered population count of pend bits. Reset and flush set it to 0.

## Timing
- Reads, cdb_hit and cdb_rd are combinational, with zero latency.
- State and pend_cnt update on the rising clk edge. A dispatch is visible to a later cycle's reads one cycle after it is presented.
- Asynchronous reset: the entries and pend_cnt clear immediately on rst_n falling, independent of clk. All outputs then read 0 (pend=0, tag=0, cdb_hit=0, cdb_rd=0, pend_cnt=0).
- Release of rst_n is synchronised externally.
- Reset asserted mid-operation discards all pending mappings.
- flush sampled at edge T empties the table in the cycle after T. Dispatches and CDB clears presented in the flush cycle are dropped.
- The counter saturates by construction at NREGS-1, since x0 is never pending.

## Structure
- Shared package rst_pkg holds:
  - rst_entry_t packed struct {pend, tag};
  - default NREGS and TAG_W localparams;
  - a function tag_match(entry, valid, tag).
- Sub-module rst_src_read, instantiated 2×DISP_W times, implements the four-level read resolution for a single source. It takes the stored entry, the lower-slot dispatch vectors and the CDB vectors.
- Top level contains the entry array, the per-entry next-state logic (flush/dispatch/clear), the CDB match one-hot-to-index encoder and the popcount register.

## Test plan
- Reset then reads: assert rst_n=0 with clk stopped → all rs*_pend=0, pend_cnt=0. Release, read x5 → pend=0, tag=0.
- Rename and wake-up: dispatch slot0 rd=5 tag=0x12. Next cycle rs1_addr=5 → pend=1, tag=0x12. Broadcast cdb_tag=0x12 → cdb_hit=1, cdb_rd=5, rs1_pend=0 same cycle. Next cycle entry 5 is ready and pend_cnt drops 1→0.
- Intra-group forward and WAW: slot0 rd=7 tag=0x03, slot1 rd=7 tag=0x04, slot1 rs2=7 → rs2_tag=0x03, pend=1. Next cycle x7 shows tag=0x04.
- Dispatch vs CDB collision: x9 pending on 0x20. In the same cycle, cdb_tag=0x20 and slot0 renames x9 to 0x21 → cdb_hit=1, cdb_rd=9. Next cycle x9 = {1, 0x21}.
- Dual CDB and x0: x3 pending on 0x01 and x4 pending on 0x02, both broadcast in one cycle → cdb_rd[0]=3, cdb_rd[1]=4, both entries cleared. A dispatch to rd=0 leaves x0 ready and pend_cnt unchanged.
- Flush: 10 entries pending. Pulse flush together with a dispatch to x11 → next cycle all pend=0, pend_cnt=0, x11 ready.
